// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes, coin values in 0.25
// units and the largest legal credit/price value.
package vending_pkg;

    localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
    localparam logic [1:0] MOEDA_025     = 2'b01;
    localparam logic [1:0] MOEDA_050     = 2'b10;
    localparam logic [1:0] MOEDA_100     = 2'b11;

    localparam logic [3:0] VALOR_025 = 4'd1;
    localparam logic [3:0] VALOR_050 = 4'd2;
    localparam logic [3:0] VALOR_100 = 4'd4;
    localparam logic [3:0] MAX_VALOR = 4'd8;

    function automatic logic [3:0] valor_moeda(input logic [1:0] m);
        logic [3:0] v;
        v = 4'd0;
        case (m)
            MOEDA_025: v = VALOR_025;
            MOEDA_050: v = VALOR_050;
            MOEDA_100: v = VALOR_100;
            default:   v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dispensador_troco_seletor_moeda.sv
// Greedy coin chooser: largest coin not exceeding the remaining change
// with stock available. Ports: troco, tem_025/050/100 in; moeda, nenhuma out.
module seletor_moeda
    import vending_pkg::*;
(
    input  logic [3:0] troco,
    input  logic       tem_025,
    input  logic       tem_050,
    input  logic       tem_100,
    output logic [1:0] moeda,
    output logic       nenhuma
);

    always_comb begin
        moeda = MOEDA_NENHUMA;
        if (tem_100 && troco >= VALOR_100) begin
            moeda = MOEDA_100;
        end else if (tem_050 && troco >= VALOR_050) begin
            moeda = MOEDA_050;
        end else if (tem_025 && troco >= VALOR_025) begin
            moeda = MOEDA_025;
        end
        nenhuma = (moeda == MOEDA_NENHUMA);
    end

endmodule

// File: rtl/dispensador_troco.sv
// Change/refund dispenser: pays out the owed amount one coin per
// valid/ack handshake and tracks per-denomination coin stock.
// Ports: clk, reset, iniciar, valorAcumulado, preco, reabastecer,
// moedaAck in; moedaSaida, moedaValida, ocupado, concluido, erro,
// trocoRestante out.
module dispensador_troco
    import vending_pkg::*;
#(
    parameter int LARGURA_EST = 4,
    parameter int ESTOQUE_025 = 8,
    parameter int ESTOQUE_050 = 4,
    parameter int ESTOQUE_100 = 2,
    parameter int TIMEOUT_ACK = 1000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] valorAcumulado,
    input  logic [3:0] preco,
    input  logic       reabastecer,
    input  logic       moedaAck,
    output logic [1:0] moedaSaida,
    output logic       moedaValida,
    output logic       ocupado,
    output logic       concluido,
    output logic       erro,
    output logic [3:0] trocoRestante
);

    localparam int TW = (TIMEOUT_ACK < 2) ? 1 : $clog2(TIMEOUT_ACK + 1);
    localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT_ACK - 1);
    localparam logic [LARGURA_EST-1:0] EST_UM = LARGURA_EST'(1);
    localparam logic [LARGURA_EST-1:0] EST_025 = LARGURA_EST'(ESTOQUE_025);
    localparam logic [LARGURA_EST-1:0] EST_050 = LARGURA_EST'(ESTOQUE_050);
    localparam logic [LARGURA_EST-1:0] EST_100 = LARGURA_EST'(ESTOQUE_100);

    typedef enum logic [2:0] {
        OCIOSO,
        CALCULA,
        OFERTA,
        FIM,
        ERRO
    } estado_t;

    estado_t              state_q, state_d;
    logic [3:0]           troco_q, troco_d;
    logic [1:0]           moeda_q, moeda_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [LARGURA_EST-1:0] est_025_q, est_025_d;
    logic [LARGURA_EST-1:0] est_050_q, est_050_d;
    logic [LARGURA_EST-1:0] est_100_q, est_100_d;

    logic [1:0] sel_moeda;
    logic       sel_nenhuma;

    seletor_moeda u_seletor (
        .troco   (troco_q),
        .tem_025 (est_025_q != '0),
        .tem_050 (est_050_q != '0),
        .tem_100 (est_100_q != '0),
        .moeda   (sel_moeda),
        .nenhuma (sel_nenhuma)
    );

    always_comb begin
        state_d   = state_q;
        troco_d   = troco_q;
        moeda_d   = moeda_q;
        tmo_d     = tmo_q;
        est_025_d = est_025_q;
        est_050_d = est_050_q;
        est_100_d = est_100_q;

        case (state_q)
            OCIOSO: begin
                // Reload shares the edge with iniciar, so the first
                // CALCULA already sees the full stock.
                if (reabastecer) begin
                    est_025_d = EST_025;
                    est_050_d = EST_050;
                    est_100_d = EST_100;
                end
                if (iniciar) begin
                    tmo_d   = '0;
                    moeda_d = MOEDA_NENHUMA;
                    if (valorAcumulado > MAX_VALOR || preco > MAX_VALOR) begin
                        troco_d = 4'd0;
                        state_d = ERRO;
                    end else if (valorAcumulado >= preco) begin
                        troco_d = valorAcumulado - preco;
                        state_d = CALCULA;
                    end else begin
                        troco_d = valorAcumulado;
                        state_d = CALCULA;
                    end
                end
            end
            CALCULA: begin
                tmo_d = '0;
                if (troco_q == 4'd0) begin
                    state_d = FIM;
                end else if (sel_nenhuma) begin
                    state_d = ERRO;
                end else begin
                    moeda_d = sel_moeda;
                    state_d = OFERTA;
                end
            end
            OFERTA: begin
                // Ack beats a simultaneous timeout.
                if (moedaAck) begin
                    troco_d = troco_q - valor_moeda(moeda_q);
                    case (moeda_q)
                        MOEDA_025:
                            if (est_025_q != '0) est_025_d = est_025_q - EST_UM;
                        MOEDA_050:
                            if (est_050_q != '0) est_050_d = est_050_q - EST_UM;
                        MOEDA_100:
                            if (est_100_q != '0) est_100_d = est_100_q - EST_UM;
                        default: ;
                    endcase
                    tmo_d   = '0;
                    moeda_d = MOEDA_NENHUMA;
                    state_d = CALCULA;
                end else if (tmo_q == TMO_FIM) begin
                    tmo_d   = '0;
                    moeda_d = MOEDA_NENHUMA;
                    state_d = ERRO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FIM:     state_d = OCIOSO;
            ERRO:    state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OCIOSO;
            troco_q   <= 4'd0;
            moeda_q   <= MOEDA_NENHUMA;
            tmo_q     <= '0;
            est_025_q <= EST_025;
            est_050_q <= EST_050;
            est_100_q <= EST_100;
        end else begin
            state_q   <= state_d;
            troco_q   <= troco_d;
            moeda_q   <= moeda_d;
            tmo_q     <= tmo_d;
            est_025_q <= est_025_d;
            est_050_q <= est_050_d;
            est_100_q <= est_100_d;
        end
    end

    assign moedaSaida    = moeda_q;
    assign moedaValida   = (state_q == OFERTA);
    assign ocupado       = (state_q != OCIOSO);
    assign concluido     = (state_q == FIM);
    assign erro          = (state_q == ERRO);
    assign trocoRestante = troco_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Bench for dispensador_troco: directed cases plus random transactions
// checked against an arithmetic change/stock model.
module tb_dispensador_troco;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] valorAcumulado;
    logic [3:0] preco;
    logic       reabastecer;
    logic       moedaAck;
    logic [1:0] moedaSaida;
    logic       moedaValida;
    logic       ocupado;
    logic       concluido;
    logic       erro;
    logic [3:0] trocoRestante;

    localparam int TMO = 1000;

    always #5 clk = ~clk;

    dispensador_troco #(.TIMEOUT_ACK(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .iniciar        (iniciar),
        .valorAcumulado (valorAcumulado),
        .preco          (preco),
        .reabastecer    (reabastecer),
        .moedaAck       (moedaAck),
        .moedaSaida     (moedaSaida),
        .moedaValida    (moedaValida),
        .ocupado        (ocupado),
        .concluido      (concluido),
        .erro           (erro),
        .trocoRestante  (trocoRestante)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int stk[3];
    int vals[3] = '{1, 2, 4};
    int coins[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reload_model();
        stk = '{8, 4, 2};
    endtask

    task automatic run(input int a, input int p, input bit reab, input int max_d);
        int owed;
        int k;
        int d;
        coins.delete();
        if (reab) reload_model();
        valorAcumulado = 4'(a);
        preco          = 4'(p);
        iniciar        = 1'b1;
        reabastecer    = reab;
        tick();
        iniciar     = 1'b0;
        reabastecer = 1'b0;
        if (a > 8 || p > 8) begin
            check("inv_erro", erro, 1);
            check("inv_troco", trocoRestante, 0);
            check("inv_valid", moedaValida, 0);
            tick();
            check("inv_idle", {ocupado, erro}, 0);
            return;
        end
        owed = (a >= p) ? a - p : a;
        check("calc_troco", trocoRestante, owed);
        check("calc_valid", moedaValida, 0);
        check("calc_busy", ocupado, 1);
        forever begin
            tick();
            if (owed == 0) begin
                check("fim_pulse", concluido, 1);
                check("fim_troco", trocoRestante, 0);
                tick();
                check("fim_idle", {ocupado, concluido}, 0);
                return;
            end
            k = -1;
            for (int i = 2; i >= 0; i--)
                if (k < 0 && stk[i] > 0 && vals[i] <= owed) k = i;
            if (k < 0) begin
                check("sem_estoque_erro", erro, 1);
                check("sem_estoque_troco", trocoRestante, owed);
                check("sem_estoque_valid", moedaValida, 0);
                tick();
                check("erro_idle", {ocupado, erro}, 0);
                return;
            end
            check("oferta_valid", moedaValida, 1);
            check("oferta_moeda", moedaSaida, k + 1);
            check("oferta_troco", trocoRestante, owed);
            coins.push_back(int'(moedaSaida));
            d = $urandom_range(0, max_d);
            repeat (d) begin
                tick();
                check("hold_valid", moedaValida, 1);
                check("hold_moeda", moedaSaida, k + 1);
            end
            moedaAck = 1'b1;
            tick();
            moedaAck = 1'b0;
            owed -= vals[k];
            stk[k]--;
            check("ack_valid", moedaValida, 0);
            check("ack_moeda", moedaSaida, 0);
            check("ack_troco", trocoRestante, owed);
        end
    endtask

    task automatic timeout_case();
        int n;
        reload_model();
        valorAcumulado = 4'd4;
        preco          = 4'd0;
        iniciar        = 1'b1;
        reabastecer    = 1'b1;
        tick();
        iniciar     = 1'b0;
        reabastecer = 1'b0;
        tick();
        check("tmo_moeda", moedaSaida, 3);
        n = 0;
        while (moedaValida && n < TMO + 100) begin
            n++;
            tick();
        end
        check("tmo_ciclos", n, TMO);
        check("tmo_erro", erro, 1);
        check("tmo_troco", trocoRestante, 4);
        tick();
        check("tmo_idle", ocupado, 0);
        check("tmo_troco_hold", trocoRestante, 4);
    endtask

    task automatic reset_case();
        reload_model();
        valorAcumulado = 4'd6;
        preco          = 4'd0;
        iniciar        = 1'b1;
        reabastecer    = 1'b1;
        tick();
        iniciar     = 1'b0;
        reabastecer = 1'b0;
        tick();
        check("rst_pre_valid", moedaValida, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_outs", {moedaSaida, moedaValida, ocupado, concluido, erro}, 0);
        check("rst_troco", trocoRestante, 0);
        reload_model();
        // Two 1,00 coins must be back after reset.
        run(8, 0, 1'b0, 1);
        check("rst_stk100", stk[2], 0);
        check("rst_ncoins", coins.size(), 2);
    endtask

    initial begin
        int a;
        int p;
        reset          = 1'b1;
        iniciar        = 1'b0;
        valorAcumulado = 4'd0;
        preco          = 4'd0;
        reabastecer    = 1'b0;
        moedaAck       = 1'b0;
        reload_model();
        tick();
        tick();
        reset = 1'b0;
        check("reset_outs", {moedaSaida, moedaValida, ocupado, concluido, erro}, 0);
        check("reset_troco", trocoRestante, 0);

        run(8, 3, 1'b1, 0);
        check("t1_ncoins", coins.size(), 2);
        if (coins.size() == 2) begin
            check("t1_c0", coins[0], 3);
            check("t1_c1", coins[1], 1);
        end
        check("t1_stk100", stk[2], 1);
        check("t1_stk025", stk[0], 7);

        run(2, 6, 1'b1, 0);
        check("t2_ncoins", coins.size(), 1);
        if (coins.size() == 1) check("t2_c0", coins[0], 2);

        run(8, 8, 1'b0, 0);
        run(9, 0, 1'b0, 0);
        run(0, 12, 1'b0, 0);

        moedaAck = 1'b1;
        tick();
        moedaAck = 1'b0;
        check("ack_ocioso", ocupado, 0);

        timeout_case();
        run(4, 0, 1'b0, 0);
        check("tmo_stk_ok", coins.size(), 1);

        reset_case();

        for (int it = 0; it < 120; it++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            p = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            run(a, p, ($urandom_range(0, 5) == 0), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
